// File: rtl/adc1_scan_ctrl.sv
// Scan controller for the adc1 modular ADC: starts single-cycle sequences on a
// trigger or a periodic timer, collects the response packet into a result bank.
module adc1_scan_ctrl #(
  parameter int NUM_CH  = 17,
  parameter int PERIOD  = 50000,
  parameter int TIMEOUT = 4096
) (
  input  logic        clock_clk,
  input  logic        reset_sink_reset_n,
  input  logic        trigger,
  input  logic        auto_en,
  output logic        csr_address,
  output logic        csr_write,
  output logic [31:0] csr_writedata,
  input  logic        rsp_valid,
  input  logic [4:0]  rsp_channel,
  input  logic [11:0] rsp_data,
  input  logic        rsp_sop,
  input  logic        rsp_eop,
  input  logic [4:0]  rd_channel,
  output logic [11:0] rd_data,
  output logic        rd_fresh,
  output logic        busy,
  output logic        scan_done,
  output logic        timeout_err,
  output logic [5:0]  sample_count
);

  localparam int              PW           = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int              TW           = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PW-1:0]   PERIOD_LAST  = PW'(PERIOD - 1);
  localparam logic [TW-1:0]   TIMEOUT_LAST = TW'(TIMEOUT - 1);
  localparam logic [5:0]      NUM_CH_W     = 6'(NUM_CH);
  localparam bit              TIMER_ON     = (PERIOD != 0);
  localparam logic [31:0]     CMD_START    = 32'h0000_0003;
  localparam logic [31:0]     CMD_STOP     = 32'h0000_0000;

  typedef enum logic [2:0] {IDLE, START, COLLECT, STOP, DONE} state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      period_cnt_q, period_cnt_d;
  logic [TW-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic [5:0]         sample_count_q, sample_count_d;
  logic [NUM_CH-1:0]  fresh_q, fresh_d;
  logic [11:0]        bank_q [NUM_CH];
  logic [11:0]        bank_d [NUM_CH];
  logic [11:0]        rd_data_q, rd_data_d;
  logic               rd_fresh_q, rd_fresh_d;
  logic               scan_req;
  logic               rsp_ch_ok;
  logic               rd_ch_ok;
  logic               sop_unused;

  // Start-of-packet adds nothing beyond eop framing.
  assign sop_unused = rsp_sop;

  assign rsp_ch_ok = ({1'b0, rsp_channel} < NUM_CH_W);
  assign rd_ch_ok  = ({1'b0, rd_channel} < NUM_CH_W);
  assign scan_req  = trigger || (TIMER_ON && auto_en && (period_cnt_q == PERIOD_LAST));

  always_comb begin
    state_d        = state_q;
    period_cnt_d   = '0;
    tmo_cnt_d      = tmo_cnt_q;
    sample_count_d = sample_count_q;
    fresh_d        = fresh_q;
    bank_d         = bank_q;

    case (state_q)
      IDLE: begin
        if (scan_req) begin
          state_d = START;
        end else if (TIMER_ON && auto_en) begin
          period_cnt_d = period_cnt_q + 1'b1;
        end
      end
      START: begin
        fresh_d        = '0;
        sample_count_d = '0;
        tmo_cnt_d      = '0;
        state_d        = COLLECT;
      end
      COLLECT: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (rsp_valid && rsp_ch_ok) begin
          bank_d[rsp_channel]  = rsp_data;
          fresh_d[rsp_channel] = 1'b1;
          if (sample_count_q != 6'd63) begin
            sample_count_d = sample_count_q + 6'd1;
          end
        end
        // An eop arriving on the last allowed cycle still completes normally.
        if (rsp_valid && rsp_eop) begin
          state_d = DONE;
        end else if (tmo_cnt_q == TIMEOUT_LAST) begin
          state_d = STOP;
        end
      end
      STOP:    state_d = IDLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reads see this cycle's bank update, giving write-through on a same-cycle hit.
  always_comb begin
    rd_data_d  = '0;
    rd_fresh_d = 1'b0;
    if (rd_ch_ok) begin
      rd_data_d  = bank_d[rd_channel];
      rd_fresh_d = fresh_d[rd_channel];
    end
  end

  always_ff @(posedge clock_clk) begin
    if (!reset_sink_reset_n) begin
      state_q        <= IDLE;
      period_cnt_q   <= '0;
      tmo_cnt_q      <= '0;
      sample_count_q <= '0;
      fresh_q        <= '0;
      rd_data_q      <= '0;
      rd_fresh_q     <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      period_cnt_q   <= period_cnt_d;
      tmo_cnt_q      <= tmo_cnt_d;
      sample_count_q <= sample_count_d;
      fresh_q        <= fresh_d;
      rd_data_q      <= rd_data_d;
      rd_fresh_q     <= rd_fresh_d;
      for (int i = 0; i < NUM_CH; i++) begin
        bank_q[i] <= bank_d[i];
      end
    end
  end

  assign csr_address   = 1'b0;
  assign csr_write     = (state_q == START) || (state_q == STOP);
  assign csr_writedata = (state_q == START) ? CMD_START : CMD_STOP;
  assign busy          = (state_q != IDLE);
  assign scan_done     = (state_q == DONE);
  assign timeout_err   = (state_q == STOP);
  assign sample_count  = sample_count_q;
  assign rd_data       = rd_data_q;
  assign rd_fresh      = rd_fresh_q;

endmodule

// File: tb/tb_adc1_scan_ctrl.sv
// Self-checking bench for adc1_scan_ctrl: a directed vector table for the
// manual scan path plus hand-written timeout, periodic and reset sequences.
module tb_adc1_scan_ctrl;

  logic        clock_clk = 1'b0;
  logic        reset_sink_reset_n = 1'b0;
  logic        trigger = 1'b0;
  logic        auto_en = 1'b0;
  logic        rsp_valid = 1'b0;
  logic [4:0]  rsp_channel = 5'd0;
  logic [11:0] rsp_data = 12'h000;
  logic        rsp_sop = 1'b0;
  logic        rsp_eop = 1'b0;
  logic [4:0]  rd_channel = 5'd0;
  logic        csr_address;
  logic        csr_write;
  logic [31:0] csr_writedata;
  logic [11:0] rd_data;
  logic        rd_fresh;
  logic        busy;
  logic        scan_done;
  logic        timeout_err;
  logic [5:0]  sample_count;

  int testsRun = 0;
  int testsFailed = 0;

  adc1_scan_ctrl #(.NUM_CH(17), .PERIOD(10), .TIMEOUT(16)) dut (
    .clock_clk          (clock_clk),
    .reset_sink_reset_n (reset_sink_reset_n),
    .trigger            (trigger),
    .auto_en            (auto_en),
    .csr_address        (csr_address),
    .csr_write          (csr_write),
    .csr_writedata      (csr_writedata),
    .rsp_valid          (rsp_valid),
    .rsp_channel        (rsp_channel),
    .rsp_data           (rsp_data),
    .rsp_sop            (rsp_sop),
    .rsp_eop            (rsp_eop),
    .rd_channel         (rd_channel),
    .rd_data            (rd_data),
    .rd_fresh           (rd_fresh),
    .busy               (busy),
    .scan_done          (scan_done),
    .timeout_err        (timeout_err),
    .sample_count       (sample_count)
  );

  always #5 clock_clk = ~clock_clk;

  typedef struct {
    logic        trig;
    logic        vld;
    logic [4:0]  ch;
    logic [11:0] dat;
    logic        eop;
    logic [4:0]  rd;
    logic        eWr;
    logic [31:0] eWd;
    logic        eBusy;
    logic        eDone;
    logic        eTerr;
    logic [5:0]  eCnt;
    logic [11:0] eRd;
    logic        eFr;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample outputs 1ns after the clock edge.
  task automatic applyStimulus(input logic trig, input logic vld, input logic [4:0] ch,
                               input logic [11:0] dat, input logic eop, input logic [4:0] rd);
    trigger     = trig;
    rsp_valid   = vld;
    rsp_sop     = vld;
    rsp_channel = ch;
    rsp_data    = dat;
    rsp_eop     = eop;
    rd_channel  = rd;
    @(posedge clock_clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 5'd0, 12'h000, 1'b0, 5'd0);
  endtask

  task automatic checkOutput(input string tag, input logic eWr, input logic [31:0] eWd,
                             input logic eBusy, input logic eDone, input logic eTerr,
                             input logic [5:0] eCnt, input logic [11:0] eRd, input logic eFr);
    chk({tag, ".csr_address"},   32'(csr_address),   32'd0);
    chk({tag, ".csr_write"},     32'(csr_write),     32'(eWr));
    chk({tag, ".csr_writedata"}, csr_writedata,      eWd);
    chk({tag, ".busy"},          32'(busy),          32'(eBusy));
    chk({tag, ".scan_done"},     32'(scan_done),     32'(eDone));
    chk({tag, ".timeout_err"},   32'(timeout_err),   32'(eTerr));
    chk({tag, ".sample_count"},  32'(sample_count),  32'(eCnt));
    chk({tag, ".rd_data"},       32'(rd_data),       32'(eRd));
    chk({tag, ".rd_fresh"},      32'(rd_fresh),      32'(eFr));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Manual scan: beats during START and in IDLE are ignored, ch20 is dropped,
    // trigger while busy is ignored, then a second scan with a duplicate channel.
    vecs[0]  = '{1'b1, 1'b0, 5'd0,  12'h000, 1'b0, 5'd0,  1'b1, 32'h3, 1'b1, 1'b0, 1'b0, 6'd0, 12'h000, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 5'd5,  12'h777, 1'b0, 5'd5,  1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 6'd0, 12'h000, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 5'd0,  12'h123, 1'b0, 5'd0,  1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 6'd1, 12'h123, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 5'd1,  12'h456, 1'b0, 5'd0,  1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 6'd2, 12'h123, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 5'd20, 12'h999, 1'b0, 5'd1,  1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 6'd2, 12'h456, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 5'd0,  12'h000, 1'b0, 5'd20, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 6'd2, 12'h000, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 5'd8,  12'hABC, 1'b1, 5'd8,  1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 6'd3, 12'hABC, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 5'd0,  12'h000, 1'b0, 5'd2,  1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd3, 12'h000, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 5'd0,  12'h000, 1'b0, 5'd1,  1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd3, 12'h456, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 5'd3,  12'h555, 1'b0, 5'd3,  1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd3, 12'h000, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 5'd0,  12'h000, 1'b0, 5'd1,  1'b1, 32'h3, 1'b1, 1'b0, 1'b0, 6'd3, 12'h456, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 5'd0,  12'h000, 1'b0, 5'd1,  1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 6'd0, 12'h456, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 5'd1,  12'h111, 1'b0, 5'd1,  1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 6'd1, 12'h111, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 5'd1,  12'h222, 1'b1, 5'd1,  1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 6'd2, 12'h222, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 5'd0,  12'h000, 1'b0, 5'd0,  1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd2, 12'h123, 1'b0};

    // Reset state
    @(posedge clock_clk);
    #1;
    @(posedge clock_clk);
    #1;
    checkOutput("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd0, 12'h000, 1'b0);
    reset_sink_reset_n = 1'b1;
    idleCycle();

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].trig, vecs[i].vld, vecs[i].ch, vecs[i].dat, vecs[i].eop, vecs[i].rd);
      checkOutput($sformatf("vec%0d", i), vecs[i].eWr, vecs[i].eWd, vecs[i].eBusy,
                  vecs[i].eDone, vecs[i].eTerr, vecs[i].eCnt, vecs[i].eRd, vecs[i].eFr);
    end

    // Timeout: STOP write 16 cycles after entering COLLECT
    applyStimulus(1'b1, 1'b0, 5'd0, 12'h000, 1'b0, 5'd0);
    chk("tmo.start_write", 32'(csr_write), 32'd1);
    chk("tmo.start_data", csr_writedata, 32'h3);
    idleCycle();
    chk("tmo.collect_busy", 32'(busy), 32'd1);
    for (int i = 1; i <= 16; i++) begin
      idleCycle();
      chk($sformatf("tmo.c%0d.csr_write", i), 32'(csr_write), 32'(i == 16));
      chk($sformatf("tmo.c%0d.timeout_err", i), 32'(timeout_err), 32'(i == 16));
      chk($sformatf("tmo.c%0d.busy", i), 32'(busy), 32'd1);
      chk($sformatf("tmo.c%0d.csr_writedata", i), csr_writedata, 32'h0);
    end
    idleCycle();
    chk("tmo.after.busy", 32'(busy), 32'd0);
    chk("tmo.after.timeout_err", 32'(timeout_err), 32'd0);
    chk("tmo.after.csr_write", 32'(csr_write), 32'd0);

    // Eop on the same cycle the timeout is reached: DONE wins
    applyStimulus(1'b1, 1'b0, 5'd0, 12'h000, 1'b0, 5'd0);
    idleCycle();
    for (int i = 1; i <= 15; i++) idleCycle();
    chk("coin.busy_before", 32'(busy), 32'd1);
    applyStimulus(1'b0, 1'b1, 5'd2, 12'h0F0, 1'b1, 5'd2);
    chk("coin.scan_done", 32'(scan_done), 32'd1);
    chk("coin.timeout_err", 32'(timeout_err), 32'd0);
    chk("coin.csr_write", 32'(csr_write), 32'd0);
    chk("coin.sample_count", 32'(sample_count), 32'd1);
    chk("coin.rd_data", 32'(rd_data), 32'h0F0);
    idleCycle();
    chk("coin.after.busy", 32'(busy), 32'd0);
    chk("coin.after.timeout_err", 32'(timeout_err), 32'd0);

    // Periodic: START lands 10 cycles after auto_en rises and after each return to IDLE
    auto_en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      idleCycle();
      chk($sformatf("per.a%0d.csr_write", i), 32'(csr_write), 32'(i == 10));
      chk($sformatf("per.a%0d.busy", i), 32'(busy), 32'(i == 10));
    end
    idleCycle();
    applyStimulus(1'b0, 1'b1, 5'd0, 12'h001, 1'b1, 5'd0);
    chk("per.a.scan_done", 32'(scan_done), 32'd1);
    idleCycle();
    chk("per.a.idle", 32'(busy), 32'd0);
    for (int i = 1; i <= 10; i++) begin
      idleCycle();
      chk($sformatf("per.b%0d.csr_write", i), 32'(csr_write), 32'(i == 10));
    end
    chk("per.b.data", csr_writedata, 32'h3);
    idleCycle();
    applyStimulus(1'b0, 1'b1, 5'd0, 12'h002, 1'b1, 5'd0);
    idleCycle();
    for (int i = 1; i <= 4; i++) idleCycle();
    chk("per.c.pre_busy", 32'(busy), 32'd0);
    auto_en = 1'b0;
    idleCycle();
    chk("per.c.gap_busy", 32'(busy), 32'd0);
    auto_en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      idleCycle();
      chk($sformatf("per.c%0d.csr_write", i), 32'(csr_write), 32'(i == 10));
    end
    auto_en = 1'b0;
    idleCycle();
    applyStimulus(1'b0, 1'b1, 5'd0, 12'h003, 1'b1, 5'd0);
    idleCycle();
    chk("per.end.busy", 32'(busy), 32'd0);

    // Reset asserted mid-COLLECT, then a clean scan
    applyStimulus(1'b1, 1'b0, 5'd0, 12'h000, 1'b0, 5'd0);
    idleCycle();
    applyStimulus(1'b0, 1'b1, 5'd4, 12'h444, 1'b0, 5'd4);
    checkOutput("rst.pre", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 6'd1, 12'h444, 1'b1);
    reset_sink_reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 5'd0, 12'h000, 1'b0, 5'd4);
    checkOutput("rst.during", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd0, 12'h000, 1'b0);
    reset_sink_reset_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 5'd0, 12'h000, 1'b0, 5'd4);
    checkOutput("rst.start", 1'b1, 32'h3, 1'b1, 1'b0, 1'b0, 6'd0, 12'h000, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd0, 12'h000, 1'b0, 5'd4);
    checkOutput("rst.collect", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 6'd0, 12'h000, 1'b0);
    applyStimulus(1'b0, 1'b1, 5'd5, 12'h050, 1'b1, 5'd5);
    checkOutput("rst.done", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 6'd1, 12'h050, 1'b1);
    idleCycle();
    chk("rst.idle.busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/adc1_scan_ctrl.md
# adc1_scan_ctrl

Scan controller for the `adc1` modular-ADC instance. It starts single-cycle conversion sequences through the sequencer CSR, either on a trigger pulse or on a periodic timer. It collects the response packet into a per-channel result bank and offers that bank through a registered read port. It sits between `adc1` and the system logic that consumes the sampled channel values.

## Interface
Parameters:
- `NUM_CH`, 17: number of channel slots in the result bank (channel indices 0..NUM_CH-1, max 32).
- `PERIOD`, 50000: clock cycles spent in IDLE before an automatic scan starts; 0 disables the timer.
- `TIMEOUT`, 4096: maximum cycles in COLLECT before the scan is aborted.

Ports:
- `clock_clk` in 1: the single clock.
- `reset_sink_reset_n` in 1: reset, synchronous and active-low.
- `trigger` in 1: one-cycle scan request.
- `auto_en` in 1: enables the periodic timer.
- `csr_address` out 1: sequencer CSR address; constant 0.
- `csr_write` out 1: sequencer CSR write strobe.
- `csr_writedata` out 32: sequencer CSR write data.
- `rsp_valid` in 1: ADC response valid.
- `rsp_channel` in 5: ADC response channel.
- `rsp_data` in 12: ADC response sample.
- `rsp_sop` in 1: ADC response start of packet.
- `rsp_eop` in 1: ADC response end of packet.
- `rd_channel` in 5: result bank read address.
- `rd_data` out 12: sample stored for `rd_channel`.
- `rd_fresh` out 1: `rd_channel` was captured in the latest scan.
- `busy` out 1: high in every state except IDLE.
- `scan_done` out 1: one-cycle pulse when a scan completes.
- `timeout_err` out 1: one-cycle pulse when a scan is aborted.
- `sample_count` out 6: number of samples captured in the current or last scan.

## Operation
- Sequencer command word:
  - bit0 is run, bits[3:1] are mode; mode 3'b001 is single-cycle.
  - START writes 32'h0000_0003.
  - STOP writes 32'h0000_0000.
- FSM states are IDLE, START, COLLECT, STOP, DONE.
- IDLE:
  - A scan request is `trigger`=1, or `auto_en`=1 with `PERIOD`≠0 and the period counter = PERIOD-1.
  - A scan request moves the FSM to START.
  - The period counter counts only in IDLE while `auto_en`=1. It clears on leaving IDLE and while `auto_en`=0.
- START:
  - `csr_write`=1 for exactly one cycle with the command word.
  - Clears the fresh bitmap, `sample_count` and the timeout counter.
  - Moves to COLLECT.
- COLLECT:
  - A beat is accepted when `rsp_valid`=1. If `rsp_channel`<NUM_CH, the bank entry is written, its fresh bit is set and `sample_count` increments, saturating at 63.
  - Channels ≥NUM_CH are dropped and not counted.
  - `rsp_sop` carries no extra meaning.
  - An accepted beat with `rsp_eop`=1 moves the FSM to DONE.
  - Otherwise, when the timeout counter reaches TIMEOUT-1, the FSM moves to STOP.
- DONE: `scan_done`=1 for one cycle, then IDLE.
- STOP: `csr_write`=1 with 32'h0, `timeout_err`=1 for one cycle, then IDLE.
- Response beats outside COLLECT, including during START, are ignored.
- `trigger` outside IDLE is ignored. Requests are not queued.
- Result bank entries keep their old value across scans; only the fresh bits are cleared at START.
- `rd_channel`≥NUM_CH returns `rd_data`=0 and `rd_fresh`=0.

## Timing
- Reset values:
  - All outputs 0; `csr_address` is always 0.
  - FSM in IDLE.
  - Bank entries, fresh bits and all counters 0.
- Reset mid-scan: the FSM returns to IDLE and no STOP write is issued, because `adc1` shares the same reset.
- Latencies:
  - `trigger` at cycle T gives `csr_write` at T+1 and `busy` high from T+1.
  - An eop beat at cycle C gives `scan_done` at C+1 and `busy` low at C+2.
- Read port: registered, one cycle of latency. `rd_data`/`rd_fresh` at cycle N+1 reflect `rd_channel` at N and bank contents at the end of N.
  - A write and a read of the same channel in the same cycle N return the newly written value at N+1.
- An eop beat in the same cycle the timeout is reached: the eop wins and the FSM goes to DONE, not STOP.
- A duplicate channel within one scan: last write wins, and `sample_count` counts both beats.

## Test plan
- Manual scan:
  - Stimulus: `trigger` pulse, then responses ch0=0x123, ch1=0x456 and ch8=0xABC with eop.
  - Required: one `csr_write` of 0x3; `scan_done` 1 cycle after eop; `sample_count`=3; reads of ch1 give 0x456 with fresh=1; ch2 gives fresh=0.
- Timeout with TIMEOUT=16:
  - Stimulus: trigger, no responses.
  - Required: STOP write of 0x0 exactly 16 cycles after COLLECT entry; `timeout_err` pulse; `busy` low the next cycle.
- Periodic mode with PERIOD=10, `auto_en`=1:
  - Required: START occurs 10 cycles after each return to IDLE.
  - Deasserting `auto_en` for one cycle restarts the 10-cycle count.
- Boundaries:
  - `rsp_channel`=20 with NUM_CH=17 → no bank change, no count.
  - eop coincident with timeout → `scan_done`, no `timeout_err`.
  - `trigger` while busy → no second CSR write.
- Reset asserted mid-COLLECT:
  - Required: all outputs 0 the next cycle.
  - A new trigger after release starts a clean scan.
